// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, forward/inverse S-box tables and
// the legal range of pipeline depths for the SubBytes unit.
package aes_pkg;

    typedef logic [7:0] byte_t;

    // The SubBytes pipeline supports one or two register stages.
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 2;

    function automatic bit stages_legal(input int s);
        return (s >= STAGES_MIN) && (s <= STAGES_MAX);
    endfunction

    localparam byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte AES S-box: forward or inverse substitution chosen per use.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic  i_inv,
    input  byte_t i_byte,
    output byte_t o_byte
);

    // Both tables see the same index; the mode only selects which result leaves.
    assign o_byte = i_inv ? SBOX_INV[i_byte] : SBOX_FWD[i_byte];

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Multi-lane AES SubBytes / InvSubBytes unit with a 1- or 2-slot
// valid/ready pipeline. Each lane is an independent byte lookup; the mode
// and sideband tag travel with every beat.
module aes_subbytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_inv
);

    localparam int DATA_W    = 8 * LANES;
    localparam bit STAGES_OK = stages_legal(STAGES);
    // An illegal depth falls back to the single-slot pipeline.
    localparam bit TWO_STAGE = STAGES_OK && (STAGES == 2);

    logic [DATA_W-1:0] w_lk_in;
    logic [DATA_W-1:0] w_lk_out;
    logic              w_lk_inv;
    logic [DATA_W-1:0] w_p0_data;
    logic              w_rdy_p0;
    logic              w_drain_p0;
    logic              w_load_p0;

    logic              r_vld_p0;
    logic [DATA_W-1:0] r_data_p0;
    logic [TAG_W-1:0]  r_tag_p0;
    logic              r_inv_p0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_byte u_sbox (
            .i_inv  (w_lk_inv),
            .i_byte (w_lk_in[8*i +: 8]),
            .o_byte (w_lk_out[8*i +: 8])
        );
    end

    if (TWO_STAGE) begin : g_two
        logic              r_vld_p1;
        logic [DATA_W-1:0] r_data_p1;
        logic [TAG_W-1:0]  r_tag_p1;
        logic              r_inv_p1;
        logic              w_rdy_p1;

        // Stage 0 holds the raw beat; the lookup sits between slot 0 and slot 1.
        assign w_p0_data  = in_data;
        assign w_lk_in    = r_data_p0;
        assign w_lk_inv   = r_inv_p0;
        assign w_rdy_p1   = !r_vld_p1 || out_ready;
        assign w_drain_p0 = r_vld_p0 && w_rdy_p1;
        assign w_rdy_p0   = !r_vld_p0 || w_rdy_p1;

        // Stage 1: capture the substituted beat, release it to downstream.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_vld_p1  <= 1'b0;
                r_data_p1 <= '0;
                r_tag_p1  <= '0;
                r_inv_p1  <= 1'b0;
            end else if (w_drain_p0) begin
                r_vld_p1  <= 1'b1;
                r_data_p1 <= w_lk_out;
                r_tag_p1  <= r_tag_p0;
                r_inv_p1  <= r_inv_p0;
            end else if (r_vld_p1 && out_ready) begin
                r_vld_p1  <= 1'b0;
            end
        end

        assign out_valid = r_vld_p1;
        assign out_data  = r_data_p1;
        assign out_tag   = r_tag_p1;
        assign out_inv   = r_inv_p1;
    end else begin : g_one
        // Lookup is combinational ahead of the only slot.
        assign w_lk_in    = in_data;
        assign w_lk_inv   = in_inv;
        assign w_p0_data  = w_lk_out;
        assign w_drain_p0 = r_vld_p0 && out_ready;
        assign w_rdy_p0   = !r_vld_p0 || out_ready;

        assign out_valid = r_vld_p0;
        assign out_data  = r_data_p0;
        assign out_tag   = r_tag_p0;
        assign out_inv   = r_inv_p0;
    end

    // Readiness depends only on slot state and out_ready, never on in_valid.
    assign in_ready  = rst_n && w_rdy_p0;
    assign w_load_p0 = in_valid && in_ready;

    // Stage 0: accept a new beat, or empty when its beat moves on unreplaced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p0  <= 1'b0;
            r_data_p0 <= '0;
            r_tag_p0  <= '0;
            r_inv_p0  <= 1'b0;
        end else if (w_load_p0) begin
            r_vld_p0  <= 1'b1;
            r_data_p0 <= w_p0_data;
            r_tag_p0  <= in_tag;
            r_inv_p0  <= in_inv;
        end else if (w_drain_p0) begin
            r_vld_p0  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Bench for aes_subbytes_pipe: a 16-lane single-stage instance (a_*) and a
// 4-lane two-stage instance (b_*), each checked through a scoreboard fed by
// an S-box model built from GF(2^8) inversion plus the affine transform.
module tb_aes_subbytes_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
    logic [127:0] a_in_data, a_out_data;
    logic [3:0]   a_in_tag, a_out_tag;
    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
    logic [31:0]  b_in_data, b_out_data;
    logic [3:0]   b_in_tag, b_out_tag;

    aes_subbytes_pipe #(.LANES(16), .STAGES(1), .TAG_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
        .in_data(a_in_data), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_tag(a_out_tag), .out_inv(a_out_inv)
    );

    aes_subbytes_pipe #(.LANES(4), .STAGES(2), .TAG_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
        .in_data(b_in_data), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_tag(b_out_tag), .out_inv(b_out_inv)
    );

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tag;
        logic         inv;
        int           cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea_in, ea_out, eb_in, eb_out;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          acc_a = 0, emit_a = 0, acc_b = 0, emit_b = 0;
    bit          lat_a = 1'b0, lat_b = 1'b0;
    logic [7:0]  fwd_m [256];
    logic [7:0]  inv_m [256];
    logic [7:0]  g;
    int          ta_tag, tb_tag;
    bit          sa, sb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input int lanes);
        logic [127:0] r = '0;
        for (int i = 0; i < lanes; i++)
            r[8*i +: 8] = inv ? inv_m[d[8*i +: 8]] : fwd_m[d[8*i +: 8]];
        return r;
    endfunction

    task automatic new_a(input int t);
        a_in_tag  = 4'(t);
        a_in_data = {$urandom, $urandom, $urandom, $urandom};
        a_in_inv  = 1'($urandom);
    endtask

    task automatic new_b(input int t);
        b_in_tag  = 4'(t);
        b_in_data = $urandom;
        b_in_inv  = 1'($urandom);
    endtask

    // Scoreboard for instance a: pop on output transfer, push on input transfer.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            emit_a++;
            n_checks++;
            assert (qa.size() != 0) else begin
                n_errors++;
                $error("FAIL a_spurious observed=%h expected=no_beat", a_out_data);
            end
            if (qa.size() != 0) begin
                ea_out = qa.pop_front();
                check("a_data", a_out_data, ea_out.data);
                check("a_tag", 128'(a_out_tag), 128'(ea_out.tag));
                check("a_inv", 128'(a_out_inv), 128'(ea_out.inv));
                if (lat_a) check("a_latency", 128'(cyc - ea_out.cyc), 128'd1);
            end
        end
        if (rst_n && a_in_valid && a_in_ready) begin
            acc_a++;
            ea_in.data = model(a_in_data, a_in_inv, 16);
            ea_in.tag  = a_in_tag;
            ea_in.inv  = a_in_inv;
            ea_in.cyc  = cyc;
            qa.push_back(ea_in);
        end
    end

    // Scoreboard for instance b.
    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            emit_b++;
            n_checks++;
            assert (qb.size() != 0) else begin
                n_errors++;
                $error("FAIL b_spurious observed=%h expected=no_beat", b_out_data);
            end
            if (qb.size() != 0) begin
                eb_out = qb.pop_front();
                check("b_data", 128'(b_out_data), eb_out.data);
                check("b_tag", 128'(b_out_tag), 128'(eb_out.tag));
                check("b_inv", 128'(b_out_inv), 128'(eb_out.inv));
                if (lat_b) check("b_latency", 128'(cyc - eb_out.cyc), 128'd2);
            end
        end
        if (rst_n && b_in_valid && b_in_ready) begin
            acc_b++;
            eb_in.data = model(128'(b_in_data), b_in_inv, 4);
            eb_in.tag  = b_in_tag;
            eb_in.inv  = b_in_inv;
            eb_in.cyc  = cyc;
            qb.push_back(eb_in);
        end
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            g = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) g = 8'(y);
            fwd_m[x] = g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_in_ready", 128'(a_in_ready), 128'd0);
        check("rst_b_in_ready", 128'(b_in_ready), 128'd0);
        check("rst_a_out_valid", 128'(a_out_valid), 128'd0);
        check("rst_a_out_data", a_out_data, 128'd0);
        check("rst_a_out_tag", 128'(a_out_tag), 128'd0);
        check("rst_a_out_inv", 128'(a_out_inv), 128'd0);
        check("rst_b_out_valid", 128'(b_out_valid), 128'd0);
        check("rst_b_out_data", 128'(b_out_data), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; a_out_ready = 1'b1; b_out_ready = 1'b1;
        @(negedge clk);
        check("rel_a_in_ready", 128'(a_in_ready), 128'd1);
        check("rel_b_in_ready", 128'(b_in_ready), 128'd1);

        // Forward single beat on the 16-lane single-stage instance
        lat_a = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_tag = 4'h5;
        a_in_data = '0;
        a_in_data[15:8] = 8'h53; a_in_data[23:16] = 8'h19;
        a_in_data[31:24] = 8'h3d; a_in_data[39:32] = 8'hff;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("fwd_valid", 128'(a_out_valid), 128'd1);
        check("fwd_lane0", 128'(a_out_data[7:0]), 128'h63);
        check("fwd_lane1", 128'(a_out_data[15:8]), 128'hed);
        check("fwd_lane2", 128'(a_out_data[23:16]), 128'hd4);
        check("fwd_lane3", 128'(a_out_data[31:24]), 128'h27);
        check("fwd_lane4", 128'(a_out_data[39:32]), 128'h16);
        check("fwd_lane15", 128'(a_out_data[127:120]), 128'h63);
        check("fwd_tag", 128'(a_out_tag), 128'h5);

        // Inverse single beat
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_inv = 1'b1; a_in_tag = 4'h6;
        a_in_data = '0;
        a_in_data[7:0] = 8'h63; a_in_data[15:8] = 8'hed; a_in_data[23:16] = 8'h16;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("inv_lane0", 128'(a_out_data[7:0]), 128'h00);
        check("inv_lane1", 128'(a_out_data[15:8]), 128'h53);
        check("inv_lane2", 128'(a_out_data[23:16]), 128'hff);
        check("inv_lane3", 128'(a_out_data[31:24]), 128'h52);
        check("inv_lane9", 128'(a_out_data[79:72]), 128'h52);
        check("inv_out_inv", 128'(a_out_inv), 128'd1);

        // Exhaustive round trip on the 4-lane two-stage instance, 1 beat/cycle
        lat_b = 1'b1;
        for (int j = 0; j < 64; j++) begin
            for (int m = 0; m < 2; m++) begin
                @(posedge clk); #1;
                b_in_valid = 1'b1;
                b_in_inv   = m[0];
                b_in_tag   = 4'(2 * j + m);
                for (int l = 0; l < 4; l++)
                    b_in_data[8*l +: 8] = m[0] ? fwd_m[4*j + l] : 8'(4*j + l);
                @(negedge clk);
                check("stream_in_ready", 128'(b_in_ready), 128'd1);
            end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stream_drained", 128'(qb.size()), 128'd0);
        check("stream_count", 128'(emit_b), 128'(acc_b));

        // Backpressure: both instances stalled for 5 cycles with input offered
        lat_a = 1'b0; lat_b = 1'b0;
        ta_tag = 0; tb_tag = 0;
        @(posedge clk); #1;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        a_in_valid = 1'b1; b_in_valid = 1'b1;
        new_a(0); new_b(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_a_in_ready", 128'(a_in_ready), 128'(i < 1));
            check("bp_b_in_ready", 128'(b_in_ready), 128'(i < 2));
            if (i >= 1) begin
                check("bp_a_out_valid", 128'(a_out_valid), 128'd1);
                check("bp_a_hold", a_out_data, qa[0].data);
                check("bp_a_hold_tag", 128'(a_out_tag), 128'd0);
            end
            if (i >= 2) begin
                check("bp_b_out_valid", 128'(b_out_valid), 128'd1);
                check("bp_b_hold", 128'(b_out_data), qb[0].data);
                check("bp_b_hold_tag", 128'(b_out_tag), 128'd0);
            end
            sa = a_in_ready; sb = b_in_ready;
            @(posedge clk); #1;
            if (sa) begin ta_tag++; new_a(ta_tag); end
            if (sb) begin tb_tag++; new_b(tb_tag); end
        end
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a_in_valid = (ta_tag < 8);
            b_in_valid = (tb_tag < 8);
            @(negedge clk);
            sa = a_in_valid && a_in_ready; sb = b_in_valid && b_in_ready;
            @(posedge clk); #1;
            if (sa) begin ta_tag++; new_a(ta_tag); end
            if (sb) begin tb_tag++; new_b(tb_tag); end
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_a_accepted", 128'(ta_tag), 128'd8);
        check("bp_b_accepted", 128'(tb_tag), 128'd8);
        check("bp_a_count", 128'(emit_a), 128'(acc_a));
        check("bp_b_count", 128'(emit_b), 128'(acc_b));

        // Reset with two beats in flight in the two-stage instance
        @(posedge clk); #1;
        b_in_valid = 1'b1; new_b(1);
        @(posedge clk); #1;
        new_b(2);
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_out_ready = 1'b0; a_out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_b_in_ready", 128'(b_in_ready), 128'd0);
        check("mid_rst_a_in_ready", 128'(a_in_ready), 128'd0);
        @(posedge clk); #1;
        check("mid_rst_out_valid", 128'(b_out_valid), 128'd0);
        check("mid_rst_out_data", 128'(b_out_data), 128'd0);
        check("mid_rst_out_tag", 128'(b_out_tag), 128'd0);
        qa.delete(); qb.delete();
        acc_a = emit_a; acc_b = emit_b;
        rst_n = 1'b1; b_out_ready = 1'b1; a_out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 128'(b_in_ready), 128'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_no_stale", 128'(b_out_valid), 128'd0);
        end

        // Drain and load in the same cycle with out_ready toggling every cycle
        ta_tag = 0; tb_tag = 0;
        @(posedge clk); #1;
        a_in_valid = 1'b1; b_in_valid = 1'b1;
        new_a(0); new_b(0);
        for (int k = 0; k < 40; k++) begin
            a_out_ready = k[0]; b_out_ready = k[0];
            @(negedge clk);
            sa = a_in_ready; sb = b_in_ready;
            @(posedge clk); #1;
            if (sa) begin ta_tag++; new_a(ta_tag); end
            if (sb) begin tb_tag++; new_b(tb_tag); end
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("tog_a_progress", 128'(ta_tag >= 20), 128'd1);
        check("tog_b_progress", 128'(tb_tag >= 20), 128'd1);
        check("tog_a_count", 128'(emit_a), 128'(acc_a));
        check("tog_b_count", 128'(emit_b), 128'(acc_b));
        check("tog_a_empty", 128'(qa.size()), 128'd0);
        check("tog_b_empty", 128'(qb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
